// File: rtl/sync_width_conv_fifo_pkg.sv
// Shared constants and helpers for the narrow-to-wide packing FIFO and its RAM.
package sync_width_conv_fifo_pkg;

    localparam logic LANE_LSB_FIRST = 1'b0;
    localparam logic LANE_MSB_FIRST = 1'b1;

    // Shape of a stored word in the 8-bit x 8 lane configuration.
    localparam int DEF_LW      = 4;
    localparam int DEF_RD_W    = 64;

    typedef struct packed {
        logic [DEF_LW-1:0]   lanes;
        logic [DEF_RD_W-1:0] data;
    } mem_word_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) res = i + 1;
            else res = res;
        end
        return res;
    endfunction

    // Physical lane that receives the cnt-th narrow word of a wide word.
    function automatic int lane_index(input int cnt, input int ratio, input logic order);
        return (order == LANE_MSB_FIRST) ? (ratio - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/sync_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read that holds when idle.
module sync_sdp_ram #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // Read register returns the old word when the same address is written in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_width_conv_fifo.sv
// Single-clock FIFO packing RATIO narrow write words into one wide read word, with
// partial-word flush, per-word lane count and water levels in both word sizes.
module sync_width_conv_fifo
    import sync_width_conv_fifo_pkg::*;
#(
    parameter int WR_DATA_WIDTH    = 8,
    parameter int RATIO            = 8,
    parameter int RD_DEPTH_WIDTH   = 12,
    parameter int ALMOST_FULL_NUM  = 32764,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter int BIG_ENDIAN       = 0,
    localparam int LW              = clog2(RATIO) + 1,
    localparam int RD_DATA_WIDTH   = WR_DATA_WIDTH * RATIO
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WR_DATA_WIDTH-1:0]     wr_data,
    input  logic                         wr_flush,
    output logic                         wr_full,
    output logic                         almost_full,
    output logic [RD_DEPTH_WIDTH+LW-1:0] wr_water_level,
    input  logic                         rd_en,
    output logic [RD_DATA_WIDTH-1:0]     rd_data,
    output logic [LW-1:0]                rd_lanes,
    output logic                         rd_valid,
    output logic                         rd_empty,
    output logic                         almost_empty,
    output logic [RD_DEPTH_WIDTH:0]      rd_water_level
);

    localparam int CW = RD_DEPTH_WIDTH + 1;
    localparam int WL = RD_DEPTH_WIDTH + LW;
    localparam logic [CW-1:0] MEM_FULL = CW'(2 ** RD_DEPTH_WIDTH);
    localparam logic [LW-1:0] RATIO_L  = LW'(RATIO);
    localparam logic [LW-1:0] LAST_L   = LW'(RATIO - 1);
    localparam logic ORDER = (BIG_ENDIAN != 0) ? LANE_MSB_FIRST : LANE_LSB_FIRST;

    typedef struct packed {
        logic [LW-1:0]            lanes;
        logic [RD_DATA_WIDTH-1:0] data;
    } word_t;

    logic [RD_DATA_WIDTH-1:0]  pack_buf_q, pack_buf_d, buf_w_s;
    logic [LW-1:0]             pack_cnt_q, pack_cnt_d, cnt_w_s;
    logic                      flush_pend_q, flush_pend_d;
    logic [RD_DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             mem_cnt_q, mem_cnt_d;
    logic [WL-1:0]             wr_level_q, wr_level_d;
    logic                      wr_full_q, almost_full_q, rd_valid_q, rd_empty_q, almost_empty_q;
    logic                      mem_full_s, wr_acc_s, pop_s, commit_s;
    word_t                     commit_word_s, ram_rd_s;

    // Packer update, commit decision and next occupancy.
    always_comb begin
        mem_full_s = (mem_cnt_q == MEM_FULL);
        wr_acc_s   = wr_en && !wr_full_q;
        pop_s      = rd_en && !rd_empty_q;
        buf_w_s    = pack_buf_q;
        for (int l = 0; l < RATIO; l++) begin
            buf_w_s[l*WR_DATA_WIDTH +: WR_DATA_WIDTH] =
                (wr_acc_s && (l == lane_index(int'(pack_cnt_q), RATIO, ORDER)))
                ? wr_data : pack_buf_q[l*WR_DATA_WIDTH +: WR_DATA_WIDTH];
        end
        cnt_w_s       = pack_cnt_q + LW'(wr_acc_s);
        commit_s      = 1'b0;
        commit_word_s = '0;
        pack_buf_d    = buf_w_s;
        pack_cnt_d    = cnt_w_s;
        flush_pend_d  = flush_pend_q;
        if (flush_pend_q) begin
            // A queued flush may share the cycle of a pop even when memory is full.
            if (!mem_full_s || pop_s) begin
                commit_s            = 1'b1;
                commit_word_s.lanes = pack_cnt_q;
                commit_word_s.data  = pack_buf_q;
                pack_buf_d          = '0;
                pack_cnt_d          = '0;
                flush_pend_d        = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end else if (cnt_w_s == RATIO_L) begin
            commit_s            = 1'b1;
            commit_word_s.lanes = RATIO_L;
            commit_word_s.data  = buf_w_s;
            pack_buf_d          = '0;
            pack_cnt_d          = '0;
        end else if (wr_flush && (cnt_w_s != '0)) begin
            if (mem_full_s) begin
                flush_pend_d = 1'b1;
            end else begin
                commit_s            = 1'b1;
                commit_word_s.lanes = cnt_w_s;
                commit_word_s.data  = buf_w_s;
                pack_buf_d          = '0;
                pack_cnt_d          = '0;
            end
        end else begin
            flush_pend_d = 1'b0;
        end
        mem_cnt_d  = mem_cnt_q + CW'(commit_s) - CW'(pop_s);
        wr_level_d = WL'(mem_cnt_d) * WL'(RATIO) + WL'(pack_cnt_d);
    end

    // State and flags, all derived from the post-edge occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_buf_q     <= '0;
            pack_cnt_q     <= '0;
            flush_pend_q   <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            mem_cnt_q      <= '0;
            wr_level_q     <= '0;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
        end else begin
            pack_buf_q     <= pack_buf_d;
            pack_cnt_q     <= pack_cnt_d;
            flush_pend_q   <= flush_pend_d;
            wr_ptr_q       <= wr_ptr_q + RD_DEPTH_WIDTH'(commit_s);
            rd_ptr_q       <= rd_ptr_q + RD_DEPTH_WIDTH'(pop_s);
            mem_cnt_q      <= mem_cnt_d;
            wr_level_q     <= wr_level_d;
            wr_full_q      <= (mem_cnt_d == MEM_FULL) && ((pack_cnt_d == LAST_L) || flush_pend_d);
            almost_full_q  <= (wr_level_d >= WL'(ALMOST_FULL_NUM));
            rd_valid_q     <= pop_s;
            rd_empty_q     <= (mem_cnt_d == '0);
            almost_empty_q <= (mem_cnt_d <= CW'(ALMOST_EMPTY_NUM));
        end
    end

    sync_sdp_ram #(
        .WIDTH      ($bits(word_t)),
        .ADDR_WIDTH (RD_DEPTH_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (commit_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (commit_word_s),
        .rd_en_i   (pop_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_s)
    );

    assign rd_data        = ram_rd_s.data;
    assign rd_lanes       = ram_rd_s.lanes;
    assign rd_valid       = rd_valid_q;
    assign rd_empty       = rd_empty_q;
    assign almost_empty   = almost_empty_q;
    assign rd_water_level = mem_cnt_q;
    assign wr_full        = wr_full_q;
    assign almost_full    = almost_full_q;
    assign wr_water_level = wr_level_q;

endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// Bench for the packing FIFO: little- and big-endian instances share stimulus and are
// checked every cycle against a queue-of-bytes reference model.
module tb_sync_width_conv_fifo;
    import sync_width_conv_fifo_pkg::*;

    localparam int R = 8;
    localparam int DEPTH = 16;
    localparam int AF = 120;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic wr_en = 1'b0, wr_flush = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] wr_full, almost_full, rd_valid, rd_empty, almost_empty;
    logic [1:0][7:0]  wr_level;
    logic [1:0][63:0] rd_data;
    logic [1:0][3:0]  rd_lanes;
    logic [1:0][4:0]  rd_level;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sync_width_conv_fifo #(
            .WR_DATA_WIDTH(8), .RATIO(R), .RD_DEPTH_WIDTH(4),
            .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE), .BIG_ENDIAN(g)
        ) dut (
            .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_flush(wr_flush),
            .wr_full(wr_full[g]), .almost_full(almost_full[g]), .wr_water_level(wr_level[g]),
            .rd_en(rd_en), .rd_data(rd_data[g]), .rd_lanes(rd_lanes[g]), .rd_valid(rd_valid[g]),
            .rd_empty(rd_empty[g]), .almost_empty(almost_empty[g]), .rd_water_level(rd_level[g])
        );
    end

    // Reference model: stored words as byte lists in arrival order, plus the partial word.
    typedef struct packed {
        logic [3:0]  n;
        logic [63:0] b;
    } entry_t;

    entry_t     q[$];
    logic [7:0] part[$];
    bit         pend;
    bit         exp_valid;
    mem_word_t  exp_rd [2];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] place(input logic [63:0] b, input int n, input int be);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[((be != 0) ? (R - 1 - i) : i) * 8 +: 8] = b[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        part.delete();
        pend = 1'b0;
        exp_valid = 1'b0;
        for (int g = 0; g < 2; g++) exp_rd[g] = '0;
    endtask

    task automatic commit_part();
        entry_t e;
        e.b = '0;
        e.n = 4'(part.size());
        for (int i = 0; i < part.size(); i++) e.b[i*8 +: 8] = part[i];
        q.push_back(e);
        part.delete();
    endtask

    task automatic compare_all();
        int lvl;
        lvl = q.size() * R + part.size();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rd_valid[%0d]", g), 64'(rd_valid[g]), 64'(exp_valid));
            chk($sformatf("rd_data[%0d]", g), rd_data[g], exp_rd[g].data);
            chk($sformatf("rd_lanes[%0d]", g), 64'(rd_lanes[g]), 64'(exp_rd[g].lanes));
            chk($sformatf("rd_empty[%0d]", g), 64'(rd_empty[g]), 64'(q.size() == 0));
            chk($sformatf("rd_level[%0d]", g), 64'(rd_level[g]), 64'(q.size()));
            chk($sformatf("wr_level[%0d]", g), 64'(wr_level[g]), 64'(lvl));
            chk($sformatf("almost_full[%0d]", g), 64'(almost_full[g]), 64'(lvl >= AF));
            chk($sformatf("almost_empty[%0d]", g), 64'(almost_empty[g]), 64'(q.size() <= AE));
            chk($sformatf("wr_full[%0d]", g), 64'(wr_full[g]),
                64'((q.size() == DEPTH) && (part.size() == R - 1 || pend)));
        end
    endtask

    // One clock cycle: drive inputs, advance the model by the same rules, check after the edge.
    task automatic step(input bit wen, input logic [7:0] wd, input bit wfl, input bit ren);
        bit full_now, pop;
        int pre;
        entry_t e;
        wr_en = wen; wr_data = wd; wr_flush = wfl; rd_en = ren;
        pre = q.size();
        full_now = (pre == DEPTH) && (part.size() == R - 1 || pend);
        pop = ren && (pre > 0);
        exp_valid = pop;
        if (pop) begin
            e = q.pop_front();
            for (int g = 0; g < 2; g++) begin
                exp_rd[g].data  = place(e.b, int'(e.n), g);
                exp_rd[g].lanes = e.n;
            end
        end
        if (wen && !full_now) part.push_back(wd);
        if (pend) begin
            if (pre < DEPTH || pop) begin
                commit_part();
                pend = 1'b0;
            end
        end else if (part.size() == R) begin
            commit_part();
        end else if (wfl && part.size() > 0) begin
            if (pre == DEPTH) pend = 1'b1;
            else commit_part();
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int wp, rp;
        model_reset();
        #1 rst_n = 1'b0;
        #2 compare_all();
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("s1_empty_after_8", 64'(rd_empty[0]), 64'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s1_le_data", rd_data[0], 64'h0807060504030201);
        chk("s1_be_data", rd_data[1], 64'h0102030405060708);
        chk("s1_lanes", 64'(rd_lanes[0]), 64'd8);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s2_le_data", rd_data[0], 64'h0000000000CCBBAA);
        chk("s2_be_data", rd_data[1], 64'hAABBCC0000000000);
        chk("s2_lanes", 64'(rd_lanes[1]), 64'd3);
        chk("s2_wr_level", 64'(wr_level[0]), 64'd0);

        write_n(DEPTH * R + 7);
        chk("s3_full", 64'(wr_full[0]), 64'd1);
        chk("s3_almost_full", 64'(almost_full[1]), 64'd1);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("s3_dropped_level", 64'(wr_level[0]), 64'd135);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s3_full_released", 64'(wr_full[0]), 64'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        drain();

        write_n(DEPTH * R + 2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("s4_pend_full", 64'(wr_full[0]), 64'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s4_level_kept", 64'(rd_level[0]), 64'd16);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s4_short_lanes", 64'(rd_lanes[0]), 64'd2);

        write_n(5 * R + 7);
        step(1'b1, 8'h5A, 1'b0, 1'b1);
        chk("s5_level_kept", 64'(rd_level[1]), 64'd5);
        drain();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s5_empty_no_valid", 64'(rd_valid[0]), 64'd0);
        chk("s5_empty_hold", rd_data[1], exp_rd[1].data);

        write_n(4 * R + 3);
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_all();
        chk("s6_reset_empty", 64'(rd_empty[1]), 64'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s6_le_data", rd_data[0], 64'h1716151413121110);
        chk("s6_be_data", rd_data[1], 64'h1011121314151617);

        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin wp = 90; rp = 20; end
                1: begin wp = 20; rp = 90; end
                2: begin wp = 60; rp = 60; end
                3: begin wp = 95; rp = 5;  end
                4: begin wp = 5;  rp = 95; end
                default: begin wp = 70; rp = 50; end
            endcase
            for (int i = 0; i < 400; i++)
                step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < 3,
                     $urandom_range(99) < rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
